// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
// Imported by the top level.
package adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   // Chunk counter width. The minimum of 1 keeps the single-chunk build legal.
   function automatic int cnt_width(input int width, input int chunk);
      int n;
      n = width / chunk;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle between a requester and seq_chunk_adder.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic             c_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;

   modport master (output start, sub, c_in, a, b,
                   input  busy, done, s, c_out, ovf);
   modport slave  (input  start, sub, c_in, a, b,
                   output busy, done, s, c_out, ovf);
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// CHUNK-bit ripple-carry slice built from full-adder cells.
// It also exposes the carry into its top bit so the parent can detect signed overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] s,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = c_in;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign c_out    = w_c[CHUNK];
   assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice reused for WIDTH/CHUNK cycles.
// Defining ADDER_OVF_EN adds the registered two's-complement overflow flag.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk per cycle, LSB chunk first, busy=1
// DONE  | single cycle with done=1; start here begins the next operation
module seq_chunk_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input logic             clk,
   input logic             reset_n,
   seq_chunk_adder_if.slave bus
);

   localparam int            N    = WIDTH / CHUNK;
   localparam int            CW   = cnt_width(WIDTH, CHUNK);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_param_check
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic             r_c_out;
   logic             r_busy;
   logic             r_done;

   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_res_next;
   logic             w_last;
`ifdef ADDER_OVF_EN
   logic             w_cmsb;
   logic             r_ovf;
`endif

   chunk_adder #(.CHUNK(CHUNK)) u_slice (
      .a        (r_a[CHUNK-1:0]),
      .b        (r_b[CHUNK-1:0]),
      .c_in     (r_carry),
      .s        (w_sum),
      .c_out    (w_cout),
`ifdef ADDER_OVF_EN
      .c_msb_in (w_cmsb)
`else
      .c_msb_in ()
`endif
   );

   // New chunk enters at the top; after N shifts the LSB chunk sits at bit 0.
   assign w_res_next = (r_sum >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
   assign w_last     = (r_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               r_state <= IDLE;
               if (bus.start) begin
                  // Subtract is a + ~b + 1; c_in then acts as a borrow-in.
                  r_a     <= bus.a;
                  r_b     <= bus.b ^ {WIDTH{bus.sub}};
                  r_carry <= bus.c_in ^ bus.sub;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_cout;
               r_sum   <= w_res_next;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_s     <= w_res_next;
                  r_c_out <= w_cout;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_OVF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_ovf <= 1'b0;
      else if ((r_state == RUN) && w_last)
         r_ovf <= w_cmsb ^ w_cout;
   end
   assign bus.ovf = r_ovf;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.s     = r_s;
   assign bus.c_out = r_c_out;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: CHUNK=4, 1 and 16 instances share stimulus.
// Checks a vector table, random operations against an integer model, and corner sequences.
module tb_seq_chunk_adder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic        c_in = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;

   always #5 clk = ~clk;

`ifdef ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   seq_chunk_adder_if #(.WIDTH(16)) if4 ();
   seq_chunk_adder_if #(.WIDTH(16)) if1 ();
   seq_chunk_adder_if #(.WIDTH(16)) if16 ();

   assign if4.start  = start;  assign if4.sub  = sub;  assign if4.c_in  = c_in;
   assign if4.a      = a;      assign if4.b    = b;
   assign if1.start  = start;  assign if1.sub  = sub;  assign if1.c_in  = c_in;
   assign if1.a      = a;      assign if1.b    = b;
   assign if16.start = start;  assign if16.sub = sub;  assign if16.c_in = c_in;
   assign if16.a     = a;      assign if16.b   = b;

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
   seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_dut1  (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
   seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));

   // index 0: CHUNK=4 (N=4), 1: CHUNK=1 (N=16), 2: CHUNK=16 (N=1)
   logic        busy_v [3];
   logic        done_v [3];
   logic [15:0] s_v    [3];
   logic        co_v   [3];
   logic        ovf_v  [3];
   assign busy_v[0] = if4.busy;  assign done_v[0] = if4.done;  assign s_v[0] = if4.s;
   assign co_v[0]   = if4.c_out; assign ovf_v[0]  = if4.ovf;
   assign busy_v[1] = if1.busy;  assign done_v[1] = if1.done;  assign s_v[1] = if1.s;
   assign co_v[1]   = if1.c_out; assign ovf_v[1]  = if1.ovf;
   assign busy_v[2] = if16.busy; assign done_v[2] = if16.done; assign s_v[2] = if16.s;
   assign co_v[2]   = if16.c_out; assign ovf_v[2] = if16.ovf;

   int          nv [3];
   logic [15:0] prev_s [3];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cin;
      logic [15:0] s;
      logic        co;
      logic        ovf;
   } vec_t;
   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Integer reference: result is a+b+cin or a-b-cin; c_out means unsigned
   // overflow for add and "no borrow" for subtract; ovf is signed range exceeded.
   task automatic model(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        input logic tc, output logic [15:0] es, output logic ec, output logic eo);
      int ua, ub, ci, sa, sb, u, sr;
      ua = int'(ta);
      ub = int'(tb_);
      ci = int'(tc);
      sa = int'($signed(ta));
      sb = int'($signed(tb_));
      if (!ts) begin
         u  = ua + ub + ci;
         sr = sa + sb + ci;
         ec = (u > 65535);
      end else begin
         u  = ua - ub - ci;
         sr = sa - sb - ci;
         ec = (u >= 0);
      end
      es = 16'(u);
      eo = OVF_EN && ((sr > 32767) || (sr < -32768));
   endtask

   // One operation on all three instances, checked cycle by cycle against each latency.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic tc, input logic [15:0] es, input logic ec, input logic eo);
      a = ta; b = tb_; sub = ts; c_in = tc; start = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("accept busy n=%0d", nv[d]), 32'(busy_v[d]), 32'(1));
         chk($sformatf("accept done n=%0d", nv[d]), 32'(done_v[d]), 32'(0));
      end
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("busy n=%0d cyc=%0d", nv[d], cyc), 32'(busy_v[d]), 32'(cyc < nv[d]));
            chk($sformatf("done n=%0d cyc=%0d", nv[d], cyc), 32'(done_v[d]), 32'(cyc == nv[d]));
            if (cyc >= nv[d]) begin
               chk($sformatf("s n=%0d a=%h b=%h sub=%b", nv[d], ta, tb_, ts), 32'(s_v[d]), 32'(es));
               chk($sformatf("c_out n=%0d a=%h b=%h", nv[d], ta, tb_), 32'(co_v[d]), 32'(ec));
               chk($sformatf("ovf n=%0d a=%h b=%h", nv[d], ta, tb_), 32'(ovf_v[d]), 32'(eo));
            end else begin
               chk($sformatf("s held n=%0d cyc=%0d", nv[d], cyc), 32'(s_v[d]), 32'(prev_s[d]));
            end
         end
      end
      for (int d = 0; d < 3; d++) prev_s[d] = es;
   endtask

   initial begin
      logic [15:0] ra, rb, es;
      logic        rs, rc, ec, eo;

      nv = '{4, 16, 1};
      for (int d = 0; d < 3; d++) prev_s[d] = '0;

      vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[7] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset busy n=%0d", nv[d]), 32'(busy_v[d]), 32'(0));
         chk($sformatf("reset done n=%0d", nv[d]), 32'(done_v[d]), 32'(0));
         chk($sformatf("reset s n=%0d", nv[d]), 32'(s_v[d]), 32'(0));
         chk($sformatf("reset c_out n=%0d", nv[d]), 32'(co_v[d]), 32'(0));
         chk($sformatf("reset ovf n=%0d", nv[d]), 32'(ovf_v[d]), 32'(0));
      end
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                vecs[i].s, vecs[i].co, OVF_EN & vecs[i].ovf);

      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rs = 1'($urandom);  rc = 1'($urandom);
         model(ra, rb, rs, rc, es, ec, eo);
         run_op(ra, rb, rs, rc, es, ec, eo);
      end

      // start re-pulsed in the 2nd RUN cycle is ignored (CHUNK=4 instance)
      a = 16'h00FF; b = 16'h0001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 16'h1234; b = 16'h1111; sub = 1'b1; start = 1'b1;
      tick();
      chk("ignore busy", 32'(if4.busy), 32'(1));
      chk("ignore done", 32'(if4.done), 32'(0));
      start = 1'b0;
      tick();
      chk("ignore busy2", 32'(if4.busy), 32'(1));
      tick();
      chk("ignore done pulse", 32'(if4.done), 32'(1));
      chk("ignore s", 32'(if4.s), 32'(16'h0100));
      chk("ignore c_out", 32'(if4.c_out), 32'(0));
      chk("ignore busy low", 32'(if4.busy), 32'(0));

      // start held during DONE: next operation begins at the next edge
      a = 16'h4000; b = 16'h0123; sub = 1'b0; c_in = 1'b1; start = 1'b1;
      tick();
      chk("b2b busy", 32'(if4.busy), 32'(1));
      chk("b2b done", 32'(if4.done), 32'(0));
      chk("b2b s held", 32'(if4.s), 32'(16'h0100));
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("b2b busy cyc=%0d", i), 32'(if4.busy), 32'(1));
         chk($sformatf("b2b done cyc=%0d", i), 32'(if4.done), 32'(0));
      end
      tick();
      chk("b2b done pulse", 32'(if4.done), 32'(1));
      chk("b2b s", 32'(if4.s), 32'(16'h4124));
      tick();
      chk("b2b done one cycle", 32'(if4.done), 32'(0));

      // reset in the 3rd RUN cycle aborts without done
      for (int i = 0; i < 20; i++) tick();
      a = 16'hABCD; b = 16'h1111; sub = 1'b0; c_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("abort busy n=%0d", nv[d]), 32'(busy_v[d]), 32'(0));
         chk($sformatf("abort done n=%0d", nv[d]), 32'(done_v[d]), 32'(0));
         chk($sformatf("abort s n=%0d", nv[d]), 32'(s_v[d]), 32'(0));
         chk($sformatf("abort c_out n=%0d", nv[d]), 32'(co_v[d]), 32'(0));
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("post-abort done n=4 cyc=%0d", i), 32'(if4.done), 32'(0));
         chk($sformatf("post-abort busy n=16 cyc=%0d", i), 32'(if16.busy), 32'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the board-level 4-bit ripple-carry adder. It adds two WIDTH-bit operands CHUNK bits per clock, reusing one CHUNK-bit ripple-carry slice and a registered carry between cycles. A start/busy/done handshake controls each operation. It sits behind the DE1-SoC top level, fed from switch and key logic or from a controller, and trades latency for a small combinational slice.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract (a − b); latched with start.
- c_in  input  1  carry-in for add, borrow-in for subtract; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when s/c_out/ovf become valid.
- s  output  WIDTH  result; held until the next completion.
- c_out  output  1  final carry out of the MSB.
- ovf  output  1  two's-complement overflow. Only functional with ADDER_OVF_EN.

## Operation
- N = WIDTH/CHUNK cycles per operation.
- States:
  - IDLE: waits for start.
  - RUN: processes one chunk per cycle, LSB chunk first; chunk counter runs 0..N−1.
  - DONE: lasts one cycle with done=1. Returns to IDLE, or goes straight to RUN if start=1 in that cycle.
- Accepting start latches a, b⊕{WIDTH{sub}}, carry0 = c_in⊕sub, and sub; the counter clears.
  - sub=1, c_in=0 gives a−b. sub=1, c_in=1 gives a−b−1.
- Each RUN cycle: the slice adds chunk i of A and B' plus the carry register. The sum chunk shifts into a result shift register and the carry register updates.
- In the last RUN cycle, s, c_out and ovf load together. Intermediate partial sums never appear on s.
- c_out is the raw carry. For subtract, c_out=1 means no borrow.
- start during RUN is ignored; there is no queueing and the operands are not re-latched.
- Input changes after acceptance have no effect on the running operation.
- Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0, ovf=0, internal registers 0.
- Reset asserted mid-operation aborts immediately. No done is produced and outputs return to their reset values.

## Timing
- start sampled high at edge k (state IDLE/DONE) → busy=1 from edge k through edge k+N−1, i.e. exactly N cycles.
- Edge k+N: done=1 for exactly one cycle, busy=0; s, c_out and ovf are valid and stable from this edge.
- Back-to-back: start held high during DONE → busy rises at the next edge. Throughput is one result per N+1 cycles.
- CHUNK=WIDTH degenerates to N=1: busy for 1 cycle, done on the next.
- Reset deassertion is synchronised externally. The block needs no warm-up cycles.

## Configuration
- ADDER_OVF_EN defined:
  - A sign-overflow register captures carry-into-MSB ⊕ carry-out-of-MSB on the final chunk.
  - ovf is valid with done and held with s.
- Undefined: the ovf logic is absent and the ovf port is tied 0.

## Structure
- Package adder_pkg holds:
  - the state typedef enum logic [1:0] {IDLE, RUN, DONE};
  - the default WIDTH/CHUNK localparams;
  - a function computing the counter width, $clog2(N) with a minimum of 1.
- Sub-module chunk_adder: a CHUNK-bit ripple-carry slice of full-adder cells. Ports: a, b, c_in, s, c_out, plus c_msb_in, the carry into the top bit, for overflow.
- Top: FSM, chunk counter, operand shift registers, carry register, result register.
- Elaboration-time $error if WIDTH % CHUNK ≠ 0.

## Test plan
All cases use WIDTH=16, CHUNK=4 unless noted.
- a=0x00FF, b=0x0001, sub=0, c_in=0 → busy 4 cycles, then done pulse with s=0x0100, c_out=0.
- a=0xFFFF, b=0x0001, add → s=0x0000, c_out=1. Same operands with c_in=1 → s=0x0001, c_out=1.
- a=0x0005, b=0x0007, sub=1, c_in=0 → s=0xFFFE, c_out=0 (borrow).
- With ADDER_OVF_EN: a=0x7FFF, b=0x0001, add → s=0x8000, ovf=1. Without the macro, ovf=0.
- start re-pulsed with new operands in the 2nd RUN cycle → ignored, first result unchanged. Then start held through DONE → second operation starts at the next edge.
- reset_n low in the 3rd RUN cycle → busy=0, s=0 immediately, no done. Repeat all cases with CHUNK=1 (N=16) and CHUNK=16 (N=1).
